// File: rtl/vx_credit_tx.sv
// Credit-based sender: forwards upstream payloads to a remote receiver buffer
// and only sends while the locally tracked receiver credit count is nonzero.
module vx_credit_tx #(
  parameter int DATAW   = 1,
  parameter int CREDITS = 4,
  parameter int OUT_REG = 0
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic                             valid_in,
  output logic                             ready_in,
  input  logic [DATAW-1:0]                 data_in,
  output logic                             valid_out,
  output logic [DATAW-1:0]                 data_out,
  input  logic                             credit_in,
  output logic [$clog2(CREDITS+1)-1:0]     credits,
  output logic                             overflow
);

  localparam int            CW        = $clog2(CREDITS + 1);
  localparam logic [CW:0]   CREDITS_X = (CW + 1)'(CREDITS);

  logic          fire;
  logic [CW:0]   credits_sum;
  logic [CW-1:0] credits_q, credits_d;
  logic          overflow_q, overflow_d;

  // ready_in looks only at registered credits and reset, never at valid_in or credit_in.
  assign ready_in = reset && (credits_q != '0);
  assign fire     = valid_in && ready_in;

  // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    credits_sum = {1'b0, credits_q} - {{CW{1'b0}}, fire} + {{CW{1'b0}}, credit_in};
    credits_d   = credits_sum[CW-1:0];
    overflow_d  = overflow_q;
    // Only reachable with credits already full, a returned credit and no send.
    if (credits_sum > CREDITS_X) begin
      credits_d  = CREDITS_X[CW-1:0];
      overflow_d = 1'b1;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
  always_ff @(posedge clk) begin
    if (!reset) begin
      credits_q  <= CREDITS_X[CW-1:0];
      overflow_q <= 1'b0;
    end else begin
      credits_q  <= credits_d;
      overflow_q <= overflow_d;
    end
  end

  assign credits  = credits_q;
  assign overflow = overflow_q;

  if (OUT_REG != 0) begin : g_reg
    logic             valid_out_q, valid_out_d;
    logic [DATAW-1:0] data_out_q, data_out_d;

    always_comb begin
      valid_out_d = fire;
      data_out_d  = fire ? data_in : data_out_q;
    end

    always_ff @(posedge clk) begin
      if (!reset) valid_out_q <= 1'b0;
      else        valid_out_q <= valid_out_d;
    end

    // NOTE: the payload register is deliberately not reset; valid_out qualifies it.
    always_ff @(posedge clk) begin
      data_out_q <= data_out_d;
    end

    assign valid_out = reset && valid_out_q;
    assign data_out  = data_out_q;
  end else begin : g_comb
    assign valid_out = fire;
    assign data_out  = data_in;
  end

  // Simulation-only checks; synthesis ignores immediate assertions.
  always @(posedge clk) begin
    assert (CREDITS >= 1 && CREDITS <= 255)
      else $error("vx_credit_tx: CREDITS=%0d outside 1..255", CREDITS);
    assert (!(reset && credit_in && !fire && credits_q == CREDITS_X[CW-1:0]))
      else $warning("vx_credit_tx: credit returned while count already full, overflow set");
  end

endmodule

// File: tb/tb_vx_credit_tx.sv
// Randomized + directed bench for vx_credit_tx; runs a combinational-output and a
// registered-output instance side by side against a credit-count reference model.
module tb_vx_credit_tx;

  localparam int CRED = 4;

  logic       clk = 1'b0;
  logic       reset;
  logic       valid_in;
  logic [7:0] data_in;
  logic       credit_in;

  logic       ready0, valid0, ovf0;
  logic [7:0] dout0;
  logic [2:0] cred0;
  logic       ready1, valid1, ovf1;
  logic [7:0] dout1;
  logic [2:0] cred1;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model state
  int         m_credits;
  bit         m_ovf;
  bit         m_vo1;
  logic [7:0] m_do1;
  bit         m_do1_known = 1'b0;
  int         n_pulse0;

  always #5 clk = ~clk;

  vx_credit_tx #(.DATAW(8), .CREDITS(CRED), .OUT_REG(0)) u_dut0 (
    .clk(clk), .reset(reset), .valid_in(valid_in), .ready_in(ready0),
    .data_in(data_in), .valid_out(valid0), .data_out(dout0),
    .credit_in(credit_in), .credits(cred0), .overflow(ovf0)
  );

  vx_credit_tx #(.DATAW(8), .CREDITS(CRED), .OUT_REG(1)) u_dut1 (
    .clk(clk), .reset(reset), .valid_in(valid_in), .ready_in(ready1),
    .data_in(data_in), .valid_out(valid1), .data_out(dout1),
    .credit_in(credit_in), .credits(cred1), .overflow(ovf1)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // One clock cycle: drive at negedge, check outputs mid-cycle, advance the model.
  task automatic cycle(input bit r, input bit v, input logic [7:0] d, input bit c);
    bit exp_ready, exp_fire;
    @(negedge clk);
    reset = r; valid_in = v; data_in = d; credit_in = c;
    #1;
    exp_ready = r && (m_credits > 0);
    exp_fire  = v && exp_ready;
    check("ready_in0", ready0, exp_ready);
    check("ready_in1", ready1, exp_ready);
    check("credits0", cred0, m_credits);
    check("credits1", cred1, m_credits);
    check("overflow0", ovf0, m_ovf);
    check("overflow1", ovf1, m_ovf);
    check("valid_out0", valid0, exp_fire);
    check("data_out0", dout0, d);
    check("valid_out1", valid1, r && m_vo1);
    if (m_do1_known) check("data_out1", dout1, m_do1);
    n_pulse0 += int'(valid0);

    if (!r) begin
      m_credits = CRED;
      m_ovf     = 1'b0;
      m_vo1     = 1'b0;
    end else begin
      if (c && !exp_fire && m_credits == CRED) m_ovf = 1'b1;
      else m_credits = m_credits - int'(exp_fire) + int'(c);
      m_vo1 = exp_fire;
      if (exp_fire) begin
        m_do1       = d;
        m_do1_known = 1'b1;
      end
    end
    @(posedge clk);
  endtask

  initial begin
    bit r, v, c;
    reset = 1'b0; valid_in = 1'b0; data_in = '0; credit_in = 1'b0;
    repeat (2) @(posedge clk);
    m_credits = CRED; m_ovf = 1'b0; m_vo1 = 1'b0;

    // Reset holds, credit pulses ignored during reset.
    cycle(0, 1, 8'h11, 1);
    cycle(0, 0, 8'h12, 1);

    // Drain all credits with valid_in held, no credit return.
    n_pulse0 = 0;
    for (int i = 0; i < 6; i++) cycle(1, 1, 8'(8'h20 + i), 0);
    check("drain_pulses", n_pulse0, 4);
    #2 check("drain_credits", cred0, 0);

    // Single credit from empty: one send next cycle, then empty again.
    cycle(1, 1, 8'h30, 1);
    cycle(1, 1, 8'h31, 0);
    cycle(1, 1, 8'h32, 0);

    // Two credits, then send and return together for 10 cycles.
    cycle(1, 0, 8'h00, 1);
    cycle(1, 0, 8'h00, 1);
    n_pulse0 = 0;
    for (int i = 0; i < 10; i++) cycle(1, 1, 8'(8'h40 + i), 1);
    check("steady_pulses", n_pulse0, 10);
    #2 check("steady_credits", cred0, 2);
    check("steady_overflow", ovf0, 0);

    // Registered output latency with 0xA5, then an idle cycle.
    cycle(1, 1, 8'hA5, 0);
    cycle(1, 0, 8'h5A, 0);
    cycle(1, 0, 8'h5A, 0);

    // Refill to full, then one extra credit: saturate and set sticky overflow.
    cycle(1, 0, 8'h00, 1);
    cycle(1, 0, 8'h00, 1);
    cycle(1, 0, 8'h00, 1);
    cycle(1, 0, 8'h00, 1);
    for (int i = 0; i < 4; i++) cycle(1, 0, 8'h00, 0);
    #2 check("ovf_sticky", ovf0, 1);
    check("ovf_saturate", cred0, CRED);

    // Reset mid-stream with one credit left and valid_in high.
    for (int i = 0; i < 3; i++) cycle(1, 1, 8'(8'h60 + i), 0);
    cycle(0, 1, 8'h70, 0);
    cycle(0, 1, 8'h71, 1);
    cycle(1, 1, 8'h72, 0);
    cycle(1, 0, 8'h73, 0);

    // Randomized traffic.
    for (int i = 0; i < 400; i++) begin
      r = ($urandom_range(0, 39) != 0);
      v = ($urandom_range(0, 1) == 1);
      c = ($urandom_range(0, 2) == 0) && ((m_credits < CRED) || v);
      cycle(r, v, 8'($urandom), c);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
